// File: rtl/matrix_pkg.sv
// matrix_pkg: shared widths and the write-arbiter state type for the
// matrix storage write path.
//   MAT_ID_W   - matrix id width
//   DIM_W      - row/column count width
//   NAME_BYTES - bytes in a matrix name
//   DATA_W     - element data width
package matrix_pkg;

  localparam int unsigned MAT_ID_W   = 3;
  localparam int unsigned DIM_W      = 8;
  localparam int unsigned NAME_BYTES = 8;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    STREAM  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: combinational round-robin search.
//   req   - request vector, one bit per requester
//   ptr   - index where the search starts; wraps modulo N
//   found - at least one request is set
//   index - first set request at or after ptr (0 when none)
module rr_priority_select #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    int unsigned cand;
    found = 1'b0;
    index = '0;
    cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        index = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/matrix_write_arbiter.sv
// matrix_write_arbiter: shares the storage manager write port between
// NUM_REQ producers. One owner is picked round-robin and holds the port
// for a whole matrix transaction (header handshake, element stream, done).
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req_want                   - per-requester level request
//   req_write_request          - per-requester write_request
//   req_matrix_id/rows/cols    - per-requester header, packed by requester
//   req_name                   - per-requester name, byte k of i at [64i+8k+:8]
//   req_data_in/data_valid     - per-requester element stream
//   req_write_ready            - write_ready forwarded to the owner only
//   req_writer_ready           - writer_ready forwarded to the owner only
//   req_write_done             - write_done forwarded to the owner only
//   grant                      - one-hot owner, 0 outside GRANT/STREAM
//   write_request .. write_done- storage manager write port
//   busy                       - arbiter not idle
//   protocol_err               - sticky: a non-owner drove valid/request
module matrix_write_arbiter
  import matrix_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_want,
  input  logic [NUM_REQ-1:0]               req_write_request,
  input  logic [NUM_REQ*MAT_ID_W-1:0]      req_matrix_id,
  input  logic [NUM_REQ*DIM_W-1:0]         req_rows,
  input  logic [NUM_REQ*DIM_W-1:0]         req_cols,
  input  logic [NUM_REQ*NAME_BYTES*8-1:0]  req_name,
  input  logic [NUM_REQ*DATA_W-1:0]        req_data_in,
  input  logic [NUM_REQ-1:0]               req_data_valid,
  output logic [NUM_REQ-1:0]               req_write_ready,
  output logic [NUM_REQ-1:0]               req_writer_ready,
  output logic [NUM_REQ-1:0]               req_write_done,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             write_request,
  input  logic                             write_ready,
  output logic [MAT_ID_W-1:0]              matrix_id,
  output logic [DIM_W-1:0]                 actual_rows,
  output logic [DIM_W-1:0]                 actual_cols,
  output logic [7:0]                       matrix_name [NAME_BYTES],
  output logic [DATA_W-1:0]                data_in,
  output logic                             data_valid,
  input  logic                             writer_ready,
  input  logic                             write_done,
  output logic                             busy,
  output logic                             protocol_err
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             owning;
  logic             in_grant;
  logic             in_stream;
  logic             owner_wr_req;
  logic             proto_violation;

  logic [MAT_ID_W-1:0] id_a   [NUM_REQ];
  logic [DIM_W-1:0]    rows_a [NUM_REQ];
  logic [DIM_W-1:0]    cols_a [NUM_REQ];
  logic [DATA_W-1:0]   data_a [NUM_REQ];
  logic [7:0]          name_a [NUM_REQ][NAME_BYTES];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign id_a[i]   = req_matrix_id[MAT_ID_W*i +: MAT_ID_W];
    assign rows_a[i] = req_rows[DIM_W*i +: DIM_W];
    assign cols_a[i] = req_cols[DIM_W*i +: DIM_W];
    assign data_a[i] = req_data_in[DATA_W*i +: DATA_W];
    for (genvar k = 0; k < NAME_BYTES; k++) begin : g_name
      assign name_a[i][k] = req_name[NAME_BYTES*8*i + 8*k +: 8];
    end
  end

  rr_priority_select #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_sel (
    .req   (req_want),
    .ptr   (rr_ptr),
    .found (sel_found),
    .index (sel_idx)
  );

  assign in_grant     = (state == GRANT);
  assign in_stream    = (state == STREAM);
  assign owning       = in_grant || in_stream;
  assign owner_wr_req = in_grant && req_write_request[owner];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = GRANT;
      GRANT: begin
        if (owner_wr_req && write_ready) state_nxt = STREAM;
        else if (!req_want[owner])       state_nxt = RELEASE;
      end
      // req_want is deliberately ignored here: the manager transaction
      // must run to write_done once started.
      STREAM:  if (write_done) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_found) owner <= sel_idx;
      // Pointer moves past the owner on every release, abandoned or not.
      if (state == RELEASE)
        rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
      if (proto_violation) protocol_err <= 1'b1;
    end
  end

  assign grant            = owning ? (NUM_REQ'(1) << owner) : '0;
  assign busy             = (state != IDLE);
  assign write_request    = owner_wr_req;
  assign req_write_ready  = (in_grant  && write_ready)  ? grant : '0;
  assign req_writer_ready = (in_stream && writer_ready) ? grant : '0;
  assign req_write_done   = (in_stream && write_done)   ? grant : '0;

  assign matrix_id   = owning    ? id_a[owner]   : '0;
  assign actual_rows = owning    ? rows_a[owner] : '0;
  assign actual_cols = owning    ? cols_a[owner] : '0;
  assign data_in     = in_stream ? data_a[owner] : '0;
  assign data_valid  = in_stream && req_data_valid[owner];

  always_comb begin
    for (int unsigned k = 0; k < NAME_BYTES; k++)
      matrix_name[k] = owning ? name_a[owner][k] : '0;
  end

  assign proto_violation = owning && (|((req_data_valid | req_write_request) & ~grant));

endmodule
